regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of write data and of the register-file word.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register address width (32 registers).
REQ-003 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk  input  1  the clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  the synchronous active-high reset.
REQ-006 The block SHALL have ports req0_valid/req1_valid  input  1 each  requester write request.
REQ-007 The block SHALL have ports req0_addr/req1_addr  input  ADDR_W each  destination register.
REQ-008 The block SHALL have ports req0_data/req1_data  input  DATA_W each  write value.
REQ-009 The block SHALL have ports req0_ready/req1_ready  output  1 each  request accepted this cycle.
REQ-010 The block SHALL have ports reserve_valid  input  1 and reserve_addr  input  ADDR_W  marking a destination as pending at issue.
REQ-011 The block SHALL have ports rs_addr/rt_addr  input  ADDR_W each  hazard query addresses.
REQ-012 The block SHALL have ports rs_busy/rt_busy/stall  output  1 each  hazard status.
REQ-013 The block SHALL have ports wr_en  output  1, wr_addr  output  ADDR_W and wr_data  output  DATA_W  driving the register-file write port.

Function
REQ-014 Acceptance SHALL be reqN_valid & reqN_ready; at most one ready SHALL be high per cycle; readyN SHALL be 0 when validN is 0.
REQ-015 With one requester valid it SHALL be granted; with both valid the grant SHALL go to the requester not granted most recently (last-grant pointer updated on every acceptance).
REQ-016 An acceptance in cycle N SHALL produce wr_en=1, wr_addr and wr_data of the accepted request in cycle N+1 (registered, latency 1); with no acceptance wr_en SHALL be 0 in N+1 and wr_addr/wr_data SHALL hold.
REQ-017 A request to address 0 SHALL be accepted normally but SHALL produce wr_en=0 in N+1.
REQ-018 The scoreboard SHALL hold one busy bit per register; busy[0] SHALL be constant 0.
REQ-019 reserve_valid with nonzero reserve_addr SHALL set busy[reserve_addr] at the clock edge; reserving an already-busy register SHALL leave it busy.
REQ-020 An acceptance in cycle N with nonzero address SHALL clear busy[addr] at the edge ending cycle N.
REQ-021 Reserve and clear of the same register at the same edge SHALL leave the bit set (newest producer wins).
REQ-022 rs_busy=busy[rs_addr], rt_busy=busy[rt_addr], stall=rs_busy|rt_busy, all combinational from current state.

Reset
REQ-023 While reset=1 at a clock edge: wr_en=0, wr_addr=0, wr_data=0, all busy bits 0, last-grant pointer set so requester 0 wins the next tie.
REQ-024 During a reset cycle req0_ready and req1_ready SHALL be 0; a write accepted in the cycle before reset SHALL be discarded (wr_en=0 after reset).

Configuration
REQ-025 Macro REGARB_ROUND_ROBIN_EN: when defined, ties SHALL be resolved per REQ-015; when undefined, requester 0 SHALL always win ties, with no pointer state; all other behaviour unchanged.

Verification
REQ-026 Reset, then req0_valid=1 addr=5 data=0x0000_00AA -> req0_ready=1 same cycle; next cycle wr_en=1 wr_addr=5 wr_data=0xAA.
REQ-027 Both valid for 4 cycles (req0 addr 3, req1 addr 4), macro defined -> grants 0,1,0,1; wr_addr 3,4,3,4 one cycle later; macro undefined -> grants 0,0,0,0.
REQ-028 req1 addr 0 data 0xFFFF_FFFF -> req1_ready=1, next cycle wr_en=0.
REQ-029 reserve addr 7; rs_addr=7 -> rs_busy=1 stall=1 next cycle; accept write to 7 -> rs_busy=0 after that edge; reserve 7 and accept write 7 same cycle -> rs_busy stays 1.
REQ-030 Accept req0 addr 9 then assert reset next cycle -> wr_en=0, wr_addr=0, all busy 0, req0/req1_ready=0 during reset.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with a per-register busy scoreboard.
// Define REGARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 wins ties.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              reserve_valid,
    input  logic [ADDR_W-1:0] reserve_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              stall,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int NREG = 1 << ADDR_W;

    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;

    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [NREG-1:0]   busy_q,    busy_d;

`ifdef REGARB_ROUND_ROBIN_EN
    // 1 means requester 1 was granted most recently, so requester 0 wins the next tie.
    logic last_grant_q, last_grant_d;
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
`ifdef REGARB_ROUND_ROBIN_EN
                if (last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
`else
                grant0 = 1'b1;
`endif
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign accept   = grant0 | grant1;
    assign acc_addr = grant1 ? req1_addr : req0_addr;
    assign acc_data = grant1 ? req1_data : req0_data;

    always_comb begin
        wr_en_d   = accept && (acc_addr != '0);
        wr_addr_d = accept ? acc_addr : wr_addr_q;
        wr_data_d = accept ? acc_data : wr_data_q;
    end

    // Reserve is applied after the clear so a same-edge reserve of the written register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (accept && (acc_addr != '0)) begin
            busy_d[acc_addr] = 1'b0;
        end
        if (reserve_valid && (reserve_addr != '0)) begin
            busy_d[reserve_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

`ifdef REGARB_ROUND_ROBIN_EN
    always_comb begin
        last_grant_d = accept ? grant1 : last_grant_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
`ifdef REGARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
`ifdef REGARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // A write accepted just before reset must never reach the register file.
    assign wr_en   = wr_en_q & ~reset;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    assign rs_busy = busy_q[rs_addr];
    assign rt_busy = busy_q[rt_addr];
    assign stall   = rs_busy | rt_busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed stimulus pushes expected writes,
// a negedge monitor pops and compares each presented register-file write.
module tb_regfile_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              reserve_valid;
    logic [ADDR_W-1:0] reserve_addr;
    logic [ADDR_W-1:0] rs_addr, rt_addr;
    logic              rs_busy, rt_busy, stall;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .reserve_valid(reserve_valid),
        .reserve_addr (reserve_addr),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .stall        (stall),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("mon_wr_addr", 32'(wr_addr), 32'(e.a));
                chk("mon_wr_data", wr_data, e.d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic exp_g1 [4];

    initial begin
`ifdef REGARB_ROUND_ROBIN_EN
        exp_g1 = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g1 = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b1; req1_addr = '0; req1_data = '0;
        reserve_valid = 1'b0; reserve_addr = '0;
        rs_addr = '0; rt_addr = '0;

        // Reset state, with both requests valid to confirm no grant during reset
        tick(); tick();
        @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_req0_ready", 32'(req0_ready), 0);
        chk("rst_req1_ready", 32'(req1_ready), 0);
        chk("rst_stall", 32'(stall), 0);
        mon_en = 1'b1;

        // Single request, latency 1
        tick();
        reset = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h0000_00AA;
        req1_valid = 1'b0;
        push(5'd5, 32'h0000_00AA);
        @(negedge clk);
        chk("t1_req0_ready", 32'(req0_ready), 1);
        chk("t1_req1_ready", 32'(req1_ready), 0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_wr_en", 32'(wr_en), 1);
        tick();
        @(negedge clk);
        chk("t1_idle_wr_en", 32'(wr_en), 0);
        chk("t1_hold_addr", 32'(wr_addr), 5);
        chk("t1_hold_data", wr_data, 32'hAA);

        // Tie arbitration from a fresh reset
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t2_req0_ready_%0d", i), 32'(req0_ready), 32'(!exp_g1[i]));
            chk($sformatf("t2_req1_ready_%0d", i), 32'(req1_ready), 32'(exp_g1[i]));
            if (exp_g1[i]) push(5'd4, 32'h44);
            else           push(5'd3, 32'h33);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Write to register 0 is accepted but suppressed
        req1_valid = 1'b1; req1_addr = '0; req1_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("t3_req1_ready", 32'(req1_ready), 1);
        chk("t3_req0_ready", 32'(req0_ready), 0);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("t3_wr_en", 32'(wr_en), 0);
        tick();

        // Scoreboard reserve / clear
        reserve_valid = 1'b1; reserve_addr = 5'd7; rs_addr = 5'd7; rt_addr = '0;
        @(negedge clk);
        chk("t4_rs_busy_before", 32'(rs_busy), 0);
        tick();
        @(negedge clk);
        chk("t4_rs_busy", 32'(rs_busy), 1);
        chk("t4_stall", 32'(stall), 1);
        chk("t4_rt_busy", 32'(rt_busy), 0);
        tick();
        reserve_valid = 1'b0;
        @(negedge clk);
        chk("t4_rereserve_busy", 32'(rs_busy), 1);
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
        push(5'd7, 32'h77);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t4_cleared_busy", 32'(rs_busy), 0);
        chk("t4_cleared_stall", 32'(stall), 0);
        tick();
        reserve_valid = 1'b1; reserve_addr = 5'd7;
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h78;
        push(5'd7, 32'h78);
        tick();
        req0_valid = 1'b0;
        reserve_addr = '0;
        @(negedge clk);
        chk("t4_same_edge_busy", 32'(rs_busy), 1);
        tick();
        reserve_valid = 1'b0;
        @(negedge clk);
        chk("t4_reg0_busy", 32'(rt_busy), 0);

        // Accept then reset: pending write dropped, scoreboard cleared
        tick();
        reserve_valid = 1'b1; reserve_addr = 5'd11;
        tick();
        reserve_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        rt_addr = 5'd11;
        @(negedge clk);
        chk("t5_req0_ready", 32'(req0_ready), 1);
        chk("t5_rt_busy_pre", 32'(rt_busy), 1);
        tick();
        reset = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("t5_rst_req0_ready", 32'(req0_ready), 0);
        chk("t5_rst_req1_ready", 32'(req1_ready), 0);
        chk("t5_rst_wr_en", 32'(wr_en), 0);
        tick();
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("t5_wr_en", 32'(wr_en), 0);
        chk("t5_wr_addr", 32'(wr_addr), 0);
        chk("t5_wr_data", wr_data, 0);
        chk("t5_rs_busy", 32'(rs_busy), 0);
        chk("t5_rt_busy", 32'(rt_busy), 0);

        tick(); tick();
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
